// File: rtl/bcd2bin_seq.sv
`default_nettype none
// ============================================================================
// Module   : bcd2bin_seq
// Purpose  : Packed-BCD to binary converter using reverse double-dabble,
//            one shift-and-correct step per clock, start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module bcd2bin_seq #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      valoare_bin,
    output logic                  err
);

    localparam int c_BCD_W = 4 * DIGITS;
    localparam int c_SR_W  = c_BCD_W + BIN_W;
    localparam int c_CNT_W = $clog2(BIN_W + 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [1:0]          r_state;
    logic [c_SR_W-1:0]   r_sr;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_err;

    logic [c_SR_W-1:0]   w_shifted;
    logic [c_BCD_W-1:0]  w_bcd_next;
    logic [DIGITS-1:0]   w_digit_bad;

    assign w_shifted = r_sr >> 1;

    // Undo the doubling carried into each digit by subtracting 3 where >= 8.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        logic [3:0] w_dig;
        assign w_dig = w_shifted[BIN_W + 4*gi +: 4];
        assign w_bcd_next[4*gi +: 4] = (w_dig >= 4'd8) ? (w_dig - 4'd3) : w_dig;
        assign w_digit_bad[gi] = (bcd_in[4*gi +: 4] > 4'd9);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_sr        <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            valoare_bin <= '0;
            err         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    busy <= start;
                    if (start) begin
                        r_sr    <= {bcd_in, {BIN_W{1'b0}}};
                        r_cnt   <= c_CNT_W'(BIN_W);
                        r_err   <= |w_digit_bad;
                        r_state <= c_SHIFT;
                    end
                end
                c_SHIFT: begin
                    busy  <= 1'b1;
                    r_sr  <= {w_bcd_next, w_shifted[BIN_W-1:0]};
                    r_cnt <= r_cnt - c_CNT_W'(1);
                    if (r_cnt == c_CNT_W'(1)) begin
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    // busy stays up through the done pulse cycle
                    busy        <= 1'b1;
                    done        <= 1'b1;
                    valoare_bin <= r_err ? '0 : r_sr[BIN_W-1:0];
                    err         <= r_err;
                    r_state     <= c_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd2bin_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd2bin_seq
// Purpose  : Scoreboard bench for bcd2bin_seq (2-digit and 3-digit instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd2bin_seq;

    localparam int c_BW2 = 7;
    localparam int c_BW3 = 10;

    typedef struct {
        int val;
        bit err;
        int when;
    } exp_t;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        start2 = 1'b0;
    logic        start3 = 1'b0;
    logic [7:0]  bcd2   = '0;
    logic [11:0] bcd3   = '0;
    logic        busy2, done2, err2, busy3, done3, err3;
    logic [c_BW2-1:0] val2;
    logic [c_BW3-1:0] val3;

    int   cyc     = 0;
    int   n_pass  = 0;
    int   n_total = 0;
    exp_t q2[$];
    exp_t q3[$];
    int   last2   = 0;
    bit   last_e2 = 1'b0;

    bcd2bin_seq #(.DIGITS(2), .BIN_W(c_BW2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .bcd_in(bcd2),
        .busy(busy2), .done(done2), .valoare_bin(val2), .err(err2)
    );

    bcd2bin_seq #(.DIGITS(3), .BIN_W(c_BW3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .bcd_in(bcd3),
        .busy(busy3), .done(done3), .valoare_bin(val3), .err(err3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    // Reference: read the digits as a decimal number with plain arithmetic.
    function automatic exp_t model(input logic [11:0] bcd, input int digits,
                                   input int acc, input int bw);
        exp_t e;
        int   v;
        int   d;
        v = 0;
        e.err = 1'b0;
        for (int i = digits - 1; i >= 0; i--) begin
            d = int'((bcd >> (4 * i)) & 12'hF);
            if (d > 9) e.err = 1'b1;
            v = v * 10 + d;
        end
        e.val  = e.err ? 0 : v;
        e.when = acc + bw + 1;
        return e;
    endfunction

    always @(negedge clk) begin : mon2
        exp_t e;
        if (!rst_n) begin
            last2   = 0;
            last_e2 = 1'b0;
        end else if (done2) begin
            if (q2.size() == 0) chk("unexpected_done2", 1, 0);
            else begin
                e = q2.pop_front();
                chk("value2", int'(val2), e.val);
                chk("err2", int'(err2), int'(e.err));
                chk("latency2", cyc, e.when);
                last2   = e.val;
                last_e2 = e.err;
            end
        end else begin
            chk("hold2", int'({err2, val2}), int'({last_e2, last2[c_BW2-1:0]}));
        end
    end

    always @(negedge clk) begin : mon3
        exp_t e;
        if (rst_n && done3) begin
            if (q3.size() == 0) chk("unexpected_done3", 1, 0);
            else begin
                e = q3.pop_front();
                chk("value3", int'(val3), e.val);
                chk("err3", int'(err3), int'(e.err));
                chk("latency3", cyc, e.when);
            end
        end
    end

    // Called at a negedge; returns at the negedge after busy should have fallen.
    task automatic conv2(input logic [7:0] bcd);
        int acc;
        acc    = cyc + 1;
        start2 = 1'b1;
        bcd2   = bcd;
        q2.push_back(model({4'h0, bcd}, 2, acc, c_BW2));
        @(negedge clk);
        start2 = 1'b0;
        bcd2   = 8'($urandom);
        chk("busy_rise", int'(busy2), 1);
        for (int j = 1; j <= c_BW2 + 1; j++) begin
            @(negedge clk);
            chk("busy_high", int'(busy2), 1);
        end
        @(negedge clk);
        chk("busy_fall", int'(busy2), 0);
    endtask

    task automatic conv3(input logic [11:0] bcd);
        int acc;
        acc    = cyc + 1;
        start3 = 1'b1;
        bcd3   = bcd;
        q3.push_back(model(bcd, 3, acc, c_BW3));
        @(negedge clk);
        start3 = 1'b0;
        bcd3   = 12'($urandom);
        repeat (c_BW3 + 1) @(negedge clk);
    endtask

    initial begin : timeout
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [7:0] dir[7];
        logic [7:0] r;
        int acc;
        dir = '{8'h00, 8'h09, 8'h10, 8'h42, 8'h99, 8'h1A, 8'h37};

        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy2), 0);
        chk("rst_done", int'(done2), 0);
        chk("rst_val", int'(val2), 0);
        chk("rst_err", int'(err2), 0);
        #2 rst_n = 1'b1;

        repeat (20) begin
            @(negedge clk);
            chk("idle_busy", int'(busy2), 0);
            chk("idle_done", int'(done2), 0);
        end

        @(negedge clk);
        foreach (dir[i]) conv2(dir[i]);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) r = 8'($urandom);
            else r = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            conv2(r);
        end

        // start held high; input changes mid-conversion
        acc    = cyc + 1;
        start2 = 1'b1;
        bcd2   = 8'h25;
        q2.push_back(model(12'h025, 2, acc, c_BW2));
        repeat (3) @(negedge clk);
        bcd2 = 8'h71;
        while (cyc < acc + c_BW2 + 1) @(negedge clk);
        q2.push_back(model(12'h071, 2, acc + c_BW2 + 2, c_BW2));
        @(negedge clk);
        start2 = 1'b0;
        repeat (c_BW2 + 3) @(negedge clk);

        // reset in the middle of a conversion
        start2 = 1'b1;
        bcd2   = 8'h88;
        @(negedge clk);
        start2 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_busy", int'(busy2), 0);
        chk("async_done", int'(done2), 0);
        chk("async_val", int'(val2), 0);
        chk("async_err", int'(err2), 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        conv2(8'h13);

        for (int v = 0; v < 1000; v++) begin
            conv3({4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)});
        end

        repeat (5) @(negedge clk);
        chk("q2_drained", q2.size(), 0);
        chk("q3_drained", q3.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
